// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: 2-bit-counter branch predictor with target table,
// mispredict recovery with a pending redirect held across pipeline stalls.
module pc_redirect_ctrl #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic             stall_dec,
  input  logic             stall_mem,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic             pc_stall,
  output logic             pc_predict,
  output logic [WIDTH-1:0] pc_pred_target,
  output logic             pc_redirect_valid,
  output logic [WIDTH-1:0] pc_redirect_target,
  output logic             flush_if,
  output logic             flush_id
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     pend_reg, pend_next;
  logic                 valid_reg [ENTRIES];
  logic [1:0]           ctr_reg   [ENTRIES];
  logic [WIDTH-1:0]     tgt_reg   [ENTRIES];

  logic [IDX_BITS-1:0]  idx_f, idx_e;
  logic                 hit;
  logic                 mispredict;
  logic [WIDTH-1:0]     recovery;
  logic                 redirect_raw;
  logic                 unused_bits;

  assign idx_f       = fetch_pc[IDX_BITS+1:2];
  assign idx_e       = ex_pc[IDX_BITS+1:2];
  assign unused_bits = ^{fetch_pc[WIDTH-1:IDX_BITS+2], fetch_pc[1:0]};

  assign pc_stall = stall_dec | stall_mem;

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign hit            = valid_reg[idx_f] & ctr_reg[idx_f][1];
  assign pc_pred_target = tgt_reg[idx_f];

  assign mispredict = ex_valid & ((ex_taken != ex_pred_taken) |
                      (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign recovery   = ex_taken ? ex_target : ex_pc + WIDTH'(4);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg[gi] <= 1'b0;
          ctr_reg[gi]   <= 2'b01;
          tgt_reg[gi]   <= '0;
        end else if (ex_valid && (idx_e == IDX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
          if (ex_taken) begin
            tgt_reg[gi] <= ex_target;
            if (ctr_reg[gi] != 2'b11) ctr_reg[gi] <= ctr_reg[gi] + 2'b01;
          end else if (ctr_reg[gi] != 2'b00) begin
            ctr_reg[gi] <= ctr_reg[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  // In PENDING further mispredicts are ignored: the oldest redirect wins.
  always_comb begin
    state_next         = state_reg;
    pend_next          = pend_reg;
    redirect_raw       = 1'b0;
    pc_redirect_target = '0;
    case (state_reg)
      IDLE: begin
        if (mispredict && reset_n) begin
          redirect_raw       = 1'b1;
          pc_redirect_target = recovery;
          if (pc_stall) begin
            pend_next  = recovery;
            state_next = PENDING;
          end
        end
      end
      PENDING: begin
        redirect_raw       = 1'b1;
        pc_redirect_target = pend_reg;
        if (!pc_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating by reset_n keeps the in-reset outputs quiet even with live ex inputs.
  assign pc_redirect_valid = redirect_raw & reset_n;
  assign pc_predict        = hit & ~pc_redirect_valid;
  assign flush_if          = pc_redirect_valid & ~pc_stall;
  assign flush_id          = pc_redirect_valid & ~pc_stall;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed cycles push expected
// outputs; a negedge monitor pops and checks whenever the DUT shows activity.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fetch_pc;
  logic        stall_dec, stall_mem;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_target;
  logic        ex_taken, ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        pc_stall, pc_predict;
  logic [31:0] pc_pred_target;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_target;
  logic        flush_if, flush_id;

  typedef struct packed {
    logic        rv;
    logic [31:0] rt;
    logic        fl;
    logic        pr;
    logic [31:0] pt;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  pc_redirect_ctrl #(.WIDTH(32), .IDX_BITS(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .fetch_pc           (fetch_pc),
    .stall_dec          (stall_dec),
    .stall_mem          (stall_mem),
    .ex_valid           (ex_valid),
    .ex_pc              (ex_pc),
    .ex_target          (ex_target),
    .ex_taken           (ex_taken),
    .ex_pred_taken      (ex_pred_taken),
    .ex_pred_target     (ex_pred_target),
    .pc_stall           (pc_stall),
    .pc_predict         (pc_predict),
    .pc_pred_target     (pc_pred_target),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target),
    .flush_if           (flush_if),
    .flush_id           (flush_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] f, input logic sd, input logic sm,
                       input logic v, input logic [31:0] pc, input logic [31:0] tg,
                       input logic tk, input logic ptk, input logic [31:0] ptg);
    fetch_pc       = f;
    stall_dec      = sd;
    stall_mem      = sm;
    ex_valid       = v;
    ex_pc          = pc;
    ex_target      = tg;
    ex_taken       = tk;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
  endtask

  task automatic idle(input logic [31:0] f);
    drive(f, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push(input logic rv, input logic [31:0] rt, input logic fl,
                      input logic pr, input logic [31:0] pt, input logic [7:0] tag);
    exp_t e;
    e.rv = rv; e.rt = rt; e.fl = fl; e.pr = pr; e.pt = pt; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: checks pc_stall every cycle, scoreboard entries on activity.
  always @(negedge clk) begin
    exp_t e;
    compared++;
    if (pc_stall !== (stall_dec | stall_mem)) begin
      mismatched++;
      $display("FAIL pc_stall: got %b want %b", pc_stall, stall_dec | stall_mem);
    end
    if (pc_redirect_valid || pc_predict || flush_if || flush_id) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: got rv=%b rt=%h fl=%b/%b pr=%b pt=%h want idle",
                 pc_redirect_valid, pc_redirect_target, flush_if, flush_id,
                 pc_predict, pc_pred_target);
      end else begin
        e = exp_q.pop_front();
        if (pc_redirect_valid !== e.rv || pc_redirect_target !== e.rt ||
            flush_if !== e.fl || flush_id !== e.fl ||
            pc_predict !== e.pr || pc_pred_target !== e.pt) begin
          mismatched++;
          $display("FAIL txn%0d: got rv=%b rt=%h fl=%b/%b pr=%b pt=%h want rv=%b rt=%h fl=%b pr=%b pt=%h",
                   e.tag, pc_redirect_valid, pc_redirect_target, flush_if, flush_id,
                   pc_predict, pc_pred_target, e.rv, e.rt, e.fl, e.pr, e.pt);
        end else begin
          $display("txn%0d ok: rv=%b rt=%h fl=%b pr=%b pt=%h",
                   e.tag, e.rv, e.rt, e.fl, e.pr, e.pt);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    idle(32'h3C);
    // In reset: live mispredict and stall must produce no outputs except pc_stall.
    tick(); drive(32'h3C, 1'b1, 1'b0, 1'b1, 32'h80, 32'h100, 1'b0, 1'b1, 32'h0);
    tick(); idle(32'h3C);
    tick(); reset_n = 1'b1; idle(32'h3C);
    tick(); idle(32'h3C);

    // Train 0x40 -> 0x100 with two taken pulses (counter 1->3).
    tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b1, 32'h100);
    tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b1, 32'h100);
    tick(); idle(32'h40); push(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 8'd1);

    // Unstalled mispredict on 0x80 (shares index 0); redirect overrides hit.
    tick(); drive(32'h40, 1'b0, 1'b0, 1'b1, 32'h80, 32'h999, 1'b0, 1'b1, 32'h100);
    push(1'b1, 32'h84, 1'b1, 1'b0, 32'h100, 8'd2);
    tick(); idle(32'h40); push(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 8'd3);

    // Stalled mispredict: pending redirect for 3 stall cycles, flush in the 4th.
    tick(); drive(32'h3C, 1'b0, 1'b1, 1'b1, 32'h104, 32'h300, 1'b1, 1'b0, 32'h0);
    push(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 8'd4);
    tick(); drive(32'h3C, 1'b0, 1'b1, 1'b1, 32'h108, 32'h0, 1'b0, 1'b1, 32'h500);
    push(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 8'd5);
    tick(); drive(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b1, 32'h300, 1'b0, 1'b0, 32'h300, 8'd6);
    tick(); idle(32'h3C); push(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 8'd7);
    tick(); idle(32'h104); push(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 8'd8);

    // Saturation on 0x40: counter 2 -> 3 (saturated) -> 2 -> 1.
    for (int i = 0; i < 5; i++) begin
      tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b1, 32'h100);
    end
    tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); idle(32'h40); push(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 8'd9);
    tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); idle(32'h40);

    // Both taken, target mismatch: redirect to actual target, entry retargeted.
    tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'h40, 32'h200, 1'b1, 1'b1, 32'h100);
    push(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 8'd10);
    tick(); idle(32'h40); push(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 8'd11);

    // Wrap-around of not-taken recovery.
    tick(); drive(32'h3C, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 32'h10);
    push(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 8'd12);

    // Enter PENDING, then assert reset mid-cycle.
    tick(); drive(32'h3C, 1'b1, 1'b0, 1'b1, 32'h104, 32'h300, 1'b1, 1'b0, 32'h0);
    push(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 8'd13);
    tick(); drive(32'h3C, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 8'd14);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if (pc_redirect_valid !== 1'b0 || pc_redirect_target !== 32'h0 ||
        flush_if !== 1'b0 || flush_id !== 1'b0 ||
        pc_predict !== 1'b0 || pc_pred_target !== 32'h0) begin
      mismatched++;
      $display("FAIL async_reset: got rv=%b rt=%h fl=%b/%b pr=%b pt=%h want all zero",
               pc_redirect_valid, pc_redirect_target, flush_if, flush_id,
               pc_predict, pc_pred_target);
    end else begin
      $display("async_reset ok: outputs zero");
    end
    tick(); idle(32'h3C);
    tick(); reset_n = 1'b1; idle(32'h40);
    tick(); idle(32'h40);
    tick(); idle(32'h3C);
    tick();

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: got %0d unconsumed expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
